mem_arbiter: RTL and testbench



---
 rtl/rv32i_types.sv | 14 +
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Types and constants shared by the memory-side blocks of the rv32i core.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  localparam logic [3:0] BE_FULL_WORD = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one registered memory port between instruction fetch and data access,
// one transaction at a time, with a bounded instruction-fetch starvation window.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic [3:0] mem_byte_enable_q, mem_byte_enable_d;
  rv32i_word  mem_address_q, mem_address_d;
  rv32i_word  mem_wdata_q, mem_wdata_d;

  logic d_pend;
  logic grant_i;
  logic grant_d;

  always_comb begin
    state_d           = state_q;
    starve_cnt_d      = starve_cnt_q;
    mem_read_d        = mem_read_q;
    mem_write_d       = mem_write_q;
    mem_byte_enable_d = mem_byte_enable_q;
    mem_address_d     = mem_address_q;
    mem_wdata_d       = mem_wdata_q;
    d_pend            = d_read | d_write;
    grant_i           = 1'b0;
    grant_d           = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins contention until the fetch side has waited LIMIT grants.
        grant_i = i_read && (!d_pend || starve_cnt_q == LIMIT);
        grant_d = d_pend && !grant_i;
        if (grant_i) begin
          state_d           = SERVE_I;
          starve_cnt_d      = 4'd0;
          mem_read_d        = 1'b1;
          mem_write_d       = 1'b0;
          mem_byte_enable_d = BE_FULL_WORD;
          mem_address_d     = i_address;
          mem_wdata_d       = '0;
        end else if (grant_d) begin
          state_d           = SERVE_D;
          mem_read_d        = d_read & ~d_write;
          mem_write_d       = d_write;
          mem_byte_enable_d = d_byte_enable;
          mem_address_d     = d_address;
          mem_wdata_d       = d_wdata;
          if (!i_read) begin
            starve_cnt_d = 4'd0;
          end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        // Address and write data deliberately keep their last values.
        if (mem_resp) begin
          state_d           = IDLE;
          mem_read_d        = 1'b0;
          mem_write_d       = 1'b0;
          mem_byte_enable_d = 4'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      starve_cnt_q      <= 4'd0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_byte_enable_q <= 4'h0;
      mem_address_q     <= '0;
      mem_wdata_q       <= '0;
    end else begin
      state_q           <= state_d;
      starve_cnt_q      <= starve_cnt_d;
      mem_read_q        <= mem_read_d;
      mem_write_q       <= mem_write_d;
      mem_byte_enable_q <= mem_byte_enable_d;
      mem_address_q     <= mem_address_d;
      mem_wdata_q       <= mem_wdata_d;
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = mem_byte_enable_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;

  assign i_resp  = (state_q == SERVE_I) && mem_resp;
  assign d_resp  = (state_q == SERVE_D) && mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // A simultaneous load and store is a requester bug; the store is issued.
  a_no_rw_together: assert property (@(posedge clk) disable iff (rst)
    !(state_q == IDLE && d_read && d_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled on the
// falling edge, so "cycle n" is the half period after rising edge n-1.
module tb_mem_arbiter;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected grant order under continuous contention with a limit of 4.
  bit         exp_is_i [6] = '{0, 0, 0, 0, 1, 0};
  logic [3:0] exp_cnt  [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

  initial begin
    rst = 1'b1; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
    d_byte_enable = 0; d_address = 0; d_wdata = 0; mem_resp = 0; mem_rdata = 0;
    tick(); tick();

    check("rst_mem_read",  32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_be",        32'(mem_byte_enable), 32'd0);
    check("rst_addr",      mem_address, 32'd0);
    check("rst_wdata",     mem_wdata, 32'd0);
    check("rst_resp",      {30'd0, i_resp, d_resp}, 32'd0);
    check("rst_state",     32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;

    // Lone fetch, memory answers in cycle 3.
    i_read = 1; i_address = 32'h60;
    tick();
    check("fetch_c1_read", 32'(mem_read), 32'd1);
    check("fetch_c1_addr", mem_address, 32'h60);
    check("fetch_c1_be",   32'(mem_byte_enable), 32'hF);
    check("fetch_c1_write", 32'(mem_write), 32'd0);
    tick();
    check("fetch_c2_hold", 32'(mem_read), 32'd1);
    check("fetch_c2_noresp", 32'(i_resp), 32'd0);
    tick();
    mem_resp = 1; mem_rdata = 32'h13; i_read = 0;
    #1;
    check("fetch_iresp",  32'(i_resp), 32'd1);
    check("fetch_irdata", i_rdata, 32'h13);
    check("fetch_dresp",  32'(d_resp), 32'd0);
    tick();
    mem_resp = 0;
    #1;
    check("fetch_pulse_end", 32'(i_resp), 32'd0);
    check("fetch_strobe_off", 32'(mem_read), 32'd0);
    check("fetch_be_off", 32'(mem_byte_enable), 32'd0);
    check("fetch_addr_held", mem_address, 32'h60);

    // Store with partial mask, memory answers in cycle 1.
    tick();
    d_write = 1; d_address = 32'h100; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
    tick();
    check("store_write", 32'(mem_write), 32'd1);
    check("store_read",  32'(mem_read), 32'd0);
    check("store_addr",  mem_address, 32'h100);
    check("store_wdata", mem_wdata, 32'hDEADBEEF);
    check("store_be",    32'(mem_byte_enable), 32'h3);
    mem_resp = 1; d_write = 0;
    #1;
    check("store_dresp", 32'(d_resp), 32'd1);
    check("store_iresp", 32'(i_resp), 32'd0);
    tick();
    mem_resp = 0;
    #1;
    check("store_strobe_off", 32'(mem_write), 32'd0);
    check("store_dresp_off", 32'(d_resp), 32'd0);
    check("store_cnt", 32'(dut.starve_cnt_q), 32'd0);

    // Contention: both sides held; each transaction answered in its cycle 1.
    i_read = 1; i_address = 32'h400; d_read = 1; d_address = 32'h500; d_byte_enable = 4'hF;
    for (int n = 0; n < 6; n++) begin
      tick();
      check($sformatf("cont%0d_read", n), 32'(mem_read), 32'd1);
      check($sformatf("cont%0d_addr", n), mem_address, exp_is_i[n] ? 32'h400 : 32'h500);
      check($sformatf("cont%0d_cnt", n), 32'(dut.starve_cnt_q), 32'(exp_cnt[n]));
      mem_resp = 1;
      #1;
      check($sformatf("cont%0d_iresp", n), 32'(i_resp), 32'(exp_is_i[n]));
      check($sformatf("cont%0d_dresp", n), 32'(d_resp), 32'(!exp_is_i[n]));
      tick();
      mem_resp = 0;
      check($sformatf("cont%0d_bubble", n), 32'(mem_read), 32'd0);
    end
    i_read = 0; d_read = 0;
    tick();
    check("cont_idle", 32'(mem_read), 32'd0);

    // Requester drops its load mid-transaction.
    d_read = 1; d_address = 32'h200;
    tick();
    check("drop_c1_read", 32'(mem_read), 32'd1);
    d_read = 0;
    tick();
    check("drop_c2_hold", 32'(mem_read), 32'd1);
    check("drop_c2_addr", mem_address, 32'h200);
    mem_resp = 1; mem_rdata = 32'hCAFE0001;
    #1;
    check("drop_dresp", 32'(d_resp), 32'd1);
    check("drop_drdata", d_rdata, 32'hCAFE0001);
    tick();
    mem_resp = 0;
    check("drop_idle", 32'(dut.state_q), 32'(IDLE));
    tick();
    check("drop_no_new", 32'(mem_read), 32'd0);
    check("drop_dresp_off", 32'(d_resp), 32'd0);

    // Spurious mem_resp in IDLE.
    mem_resp = 1;
    #1;
    check("spur_resp", {30'd0, i_resp, d_resp}, 32'd0);
    tick();
    mem_resp = 0;
    check("spur_state", 32'(dut.state_q), 32'(IDLE));
    check("spur_read", 32'(mem_read), 32'd0);

    // Asynchronous reset in the middle of a fetch.
    i_read = 1; i_address = 32'h80;
    tick();
    check("arst_before", 32'(mem_read), 32'd1);
    #2 rst = 1; mem_resp = 1;
    #1;
    check("arst_read_drop", 32'(mem_read), 32'd0);
    check("arst_no_iresp", 32'(i_resp), 32'd0);
    tick();
    rst = 0; mem_resp = 0;
    tick();
    check("reissue_read", 32'(mem_read), 32'd1);
    check("reissue_addr", mem_address, 32'h80);
    mem_resp = 1; mem_rdata = 32'h00000093; i_read = 0;
    #1;
    check("reissue_iresp", 32'(i_resp), 32'd1);
    check("reissue_rdata", i_rdata, 32'h00000093);
    tick();
    mem_resp = 0;
    check("reissue_done", 32'(mem_read), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
